fft_reorder_out: RTL and testbench
==================================

// Module: fft_reorder_out
//
// PURPOSE
//  Parametrised output-reorder stage placed after the last FFT butterfly
//  stage. Captures each frame into a ping-pong RAM and replays it in
//  natural bin order, or in raw (bit-reversed) order when bypass is
//  selected. Converts results from IWIDTH to OWIDTH using convergent
//  rounding with saturation. Gates output on the first frame sync and
//  recovers from early or short frames.
//
// PARAMETERS
//  LGSIZE  11  log2 of the FFT frame length N; LGSIZE >= 2
//  IWIDTH  22  bits per real/imag component at input
//  OWIDTH  22  bits per component at output; OWIDTH <= IWIDTH
//  ROUND   1   1: convergent round plus saturate; 0: truncate low bits
//
// PORTS
//  i_clk            in   1         clock
//  i_reset          in   1         reset i_reset, synchronous, active-high; clock i_clk
//  i_ce             in   1         clock enable; one input sample per asserted cycle
//  i_sync           in   1         i_sample is sample 0 of a frame
//  i_sample         in   2*IWIDTH  {real, imag}, two's complement
//  i_bypass         in   1         1: output frame in received (bit-reversed) order
//  o_result         out  2*OWIDTH  {real, imag}, two's complement
//  o_sync           out  1         o_result is bin 0 of an output frame
//  o_resync         out  1         one-cycle pulse: i_sync arrived mid-frame
//
// BEHAVIOUR
//  - State changes only on cycles with i_ce=1, except reset.
//  - Reset: clears started, write index, bank, frame_valid, o_result,
//    o_sync and o_resync to 0.
//  - started: set on the first i_ce && i_sync. Until it is set, input
//    samples are discarded. Gated sync is active = started || i_sync.
//  - Write: while active, mem[{wbank, widx}] <= i_sample and widx
//    increments by 1.
//    - When widx wraps from N-1 to 0, wbank toggles and frame_valid is set.
//  - Mode: i_bypass is latched into rmode only when a frame finishes
//    writing. A frame is always read with the mode in force when it
//    was written.
//  - Read: during the write of frame F+1, bank !wbank (frame F) is read
//    at address widx when rmode=1, or bitrev(widx) when rmode=0.
//  - Pipeline: RAM read register, then rounding register, then o_result.
//    - Bin 0 of frame F appears on o_result exactly N+2 active i_ce
//      cycles after frame F's sync is accepted.
//    - o_sync is high on that cycle only, and only once frame_valid is set.
//    - The pipeline delays o_sync with the data.
//  - Early sync: i_ce && i_sync while started and widx != 0.
//    - The partial frame is discarded: wbank is not toggled and
//      frame_valid is unchanged.
//    - The sample is written at index 0 and widx becomes 1.
//    - o_resync pulses for one i_ce cycle.
//    - Output of the previously completed frame continues unbroken.
//  - Syncs on time: an i_sync at widx == 0 is normal. A missing sync at
//    wrap is tolerated; the frame boundary is set by the counter.
//  - Width conversion, with D = IWIDTH - OWIDTH per component:
//    - D = 0: pass through.
//    - ROUND=0: keep the top OWIDTH bits.
//    - ROUND=1: add {kept_lsb, {(D-1){!kept_lsb}}} (ties round to even),
//      then keep the top OWIDTH bits.
//      A positive overflow saturates to 2^(OWIDTH-1)-1. Negative values
//      never overflow.
//  - i_ce low: all registers hold, including o_result, o_sync and
//    o_resync.
//  - Reset mid-frame: all frame data is abandoned. After reset, output
//    begins only N+2 cycles after the next sync.
//
// TESTING  (LGSIZE=3, N=8 unless stated)
//  1. Sync, then frames of real=k, imag=-k for k=0..7, repeated.
//     -> Second frame period outputs real 0,1,2,...,7 in natural order
//        (input 0,4,2,6,1,5,3,7).
//     -> o_sync high with bin 0, exactly 10 i_ce cycles after the first sync.
//  2. i_bypass=1 from reset, ramp input 0..7.
//     -> Output 0..7 in received order.
//     -> Toggling i_bypass mid-frame changes order only from the next
//        frame's output.
//  3. Five samples with i_sync=0, then a sync and a ramp.
//     -> The first five samples never appear on output.
//     -> o_sync first rises 10 cycles after the sync.
//  4. Sync at widx=5.
//     -> o_resync pulses once; the prior frame's output is unbroken.
//     -> The new frame is output intact, N+2 cycles after the early sync.
//  5. IWIDTH=22, OWIDTH=16 (D=6), ROUND=1, real inputs per sample
//     -> Inputs 0x20 -> 0; 0x60 -> 2; 0xA0 -> 2; 0xE0 -> 4.
//     -> Input 0x1FFFFF -> 0x7FFF (saturated).
//     -> Input -0x20 (0x3FFFE0) -> 0.
//  6. i_ce toggled randomly during test 1 -> same output sequence on i_ce
//     cycles. Reset asserted at widx=3 -> o_sync/o_result = 0 next cycle.

Source files
------------

// File: rtl/fft_reorder_out.sv
// fft_reorder_out: output reorder stage after the last FFT butterfly.
// Frames are captured into a ping-pong RAM. Each frame is replayed in natural
// bin order, or in received (bit-reversed) order when bypass is selected.
// Samples are converted from IWIDTH to OWIDTH per component, using convergent
// rounding with saturation or plain truncation.
module fft_reorder_out #(
   parameter int unsigned LGSIZE = 11,
   parameter int unsigned IWIDTH = 22,
   parameter int unsigned OWIDTH = 22,
   parameter int unsigned ROUND  = 1
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_ce,
   input  logic                i_sync,
   input  logic [2*IWIDTH-1:0] i_sample,
   input  logic                i_bypass,
   output logic [2*OWIDTH-1:0] o_result,
   output logic                o_sync,
   output logic                o_resync
);

   localparam int unsigned N = 1 << LGSIZE;
   localparam int unsigned D = IWIDTH - OWIDTH;

   logic [2*IWIDTH-1:0] r_mem [0:2*N-1];

   logic                r_started;
   logic                r_wbank;
   logic                r_frame_valid;
   logic                r_rmode;
   logic                r_rvalid;
   logic [LGSIZE-1:0]   r_widx;
   logic [LGSIZE-1:0]   r_ridx;
   logic [2*IWIDTH-1:0] r_rdata;
   logic                r_rsync;
   logic [2*OWIDTH-1:0] r_round;
   logic                r_csync;

   logic                w_active;
   logic                w_early;
   logic                w_wrap;
   logic [LGSIZE-1:0]   w_wa;
   logic [LGSIZE-1:0]   w_rev;
   logic [LGSIZE-1:0]   w_raddr;
   logic [2*OWIDTH-1:0] w_conv;

   assign w_active = r_started || i_sync;
   // A sync arriving mid-frame restarts the write at index 0 of the same bank.
   assign w_early  = r_started && i_sync && (r_widx != '0);
   assign w_wa     = w_early ? '0 : r_widx;
   assign w_wrap   = w_active && (&w_wa);

   // Bit-reverse the read index for natural-order replay.
   always_comb begin
      w_rev = '0;
      for (int b = 0; b < int'(LGSIZE); b++) begin
         w_rev[b] = r_ridx[LGSIZE-1-b];
      end
   end

   assign w_raddr = r_rmode ? r_ridx : w_rev;

   // Write-side and replay-side sequencing.
   // The replay counter is separate from the write index so an early sync
   // does not disturb replay of the previously completed frame.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_started     <= 1'b0;
         r_widx        <= '0;
         r_wbank       <= 1'b0;
         r_frame_valid <= 1'b0;
         r_rmode       <= 1'b0;
         r_rvalid      <= 1'b0;
         r_ridx        <= '0;
         o_resync      <= 1'b0;
      end else if (i_ce) begin
         o_resync <= w_early;
         if (i_sync) begin
            r_started <= 1'b1;
         end
         if (w_active) begin
            r_widx <= w_wa + LGSIZE'(1);
            if (w_wrap) begin
               r_wbank       <= ~r_wbank;
               r_frame_valid <= 1'b1;
               r_rmode       <= i_bypass;
            end
         end
         if (w_wrap) begin
            r_rvalid <= 1'b1;
            r_ridx   <= '0;
         end else if (r_rvalid) begin
            r_ridx <= r_ridx + LGSIZE'(1);
            if (&r_ridx) begin
               r_rvalid <= 1'b0;
            end
         end
      end
   end

   // Capture incoming samples into the bank being filled.
   always_ff @(posedge i_clk) begin
      if (i_ce && w_active) begin
         r_mem[{r_wbank, w_wa}] <= i_sample;
      end
   end

   // RAM read register; idle slots read as zero.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rdata <= '0;
         r_rsync <= 1'b0;
      end else if (i_ce) begin
         r_rdata <= r_rvalid ? r_mem[{~r_wbank, w_raddr}] : '0;
         r_rsync <= r_rvalid && (r_ridx == '0) && r_frame_valid;
      end
   end

   for (genvar c = 0; c < 2; c++) begin : g_comp
      logic [IWIDTH-1:0] w_x;
      assign w_x = r_rdata[c*IWIDTH +: IWIDTH];
      if (D == 0 || ROUND == 0) begin : g_trunc
         assign w_conv[c*OWIDTH +: OWIDTH] = w_x[IWIDTH-1:D];
         if (D > 0) begin : g_drop
            logic w_unused_lo;
            assign w_unused_lo = ^w_x[D-1:0];
         end
      end else begin : g_round
         logic [IWIDTH:0] w_add;
         logic [IWIDTH:0] w_sum;
         logic            w_unused_lo;
         // Half an output LSB, minus one when the kept LSB is even: ties go to even.
         assign w_add = ({{IWIDTH{1'b0}}, 1'b1} << (D - 1)) - {{IWIDTH{1'b0}}, ~w_x[D]};
         assign w_sum = {w_x[IWIDTH-1], w_x} + w_add;
         // Only positive values can carry into the sign bit.
         assign w_conv[c*OWIDTH +: OWIDTH] = (w_sum[IWIDTH] != w_sum[IWIDTH-1]) ?
                                             {1'b0, {(OWIDTH-1){1'b1}}} : w_sum[IWIDTH-1:D];
         assign w_unused_lo = ^w_sum[D-1:0];
      end
   end

   // Rounding register, then output register; sync travels with the data.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_round  <= '0;
         r_csync  <= 1'b0;
         o_result <= '0;
         o_sync   <= 1'b0;
      end else if (i_ce) begin
         r_round  <= w_conv;
         r_csync  <= r_rsync;
         o_result <= r_round;
         o_sync   <= r_csync;
      end
   end

endmodule

// File: tb/tb_fft_reorder_out.sv
// Testbench for fft_reorder_out: directed and randomized frames compared
// against a frame-queue reference model that schedules expected outputs.
module tb_fft_reorder_out;

   localparam int LG = 3;
   localparam int N  = 8;
   localparam int IW = 22;
   localparam int OW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            ce;
   logic            sync;
   logic            byp;
   logic [2*IW-1:0] smp;
   logic [2*OW-1:0] res;
   logic            osync;
   logic            oresync;

   always #5 clk = ~clk;

   fft_reorder_out #(
      .LGSIZE(LG),
      .IWIDTH(IW),
      .OWIDTH(OW),
      .ROUND (1)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_ce    (ce),
      .i_sync  (sync),
      .i_sample(smp),
      .i_bypass(byp),
      .o_result(res),
      .o_sync  (osync),
      .o_resync(oresync)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_edge   = 0;
   int first_sync  = -1;
   int first_osync = -1;

   // Reference model state: samples of the frame in progress and the
   // predicted outputs keyed by the active-edge index they appear on.
   bit              started = 1'b0;
   logic [2*IW-1:0] frame_q[$];
   bit              exp_sync[int];
   bit              exp_resync[int];
   logic [2*OW-1:0] exp_res[int];

   bit          cap_arm = 1'b0;
   int          cap_n   = N;
   logic [15:0] cap[N];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n_edge);
   endtask

   function automatic int bitrev(input int v);
      int r = 0;
      for (int b = 0; b < LG; b++) r = r * 2 + ((v >> b) & 1);
      return r;
   endfunction

   // Convergent rounding from 22 to 16 bits, by integer arithmetic.
   function automatic logic [15:0] conv_c(input logic [IW-1:0] x);
      longint v, q, r;
      v = longint'($signed(x));
      q = v >>> 6;
      r = v - q * 64;
      if (r > 32 || (r == 32 && (q & 1) != 0)) q = q + 1;
      if (q > 32767) q = 32767;
      return q[15:0];
   endfunction

   task automatic model_edge(input bit s, input logic [2*IW-1:0] x, input bit b);
      if (!started && !s) return;
      if (s && first_sync < 0) first_sync = n_edge;
      started = 1'b1;
      if (s && frame_q.size() != 0) begin
         frame_q.delete();
         exp_resync[n_edge] = 1'b1;
      end
      frame_q.push_back(x);
      if (frame_q.size() == N) begin
         for (int j = 0; j < N; j++) begin
            logic [2*IW-1:0] v;
            v = frame_q[b ? j : bitrev(j)];
            exp_res[n_edge + 3 + j] = {conv_c(v[2*IW-1:IW]), conv_c(v[IW-1:0])};
         end
         exp_sync[n_edge + 3] = 1'b1;
         frame_q.delete();
      end
   endtask

   task automatic check_out();
      int e;
      e = n_edge - 1;
      check("o_sync", 32'(osync), 32'(exp_sync.exists(e)));
      check("o_resync", 32'(oresync), 32'(exp_resync.exists(e)));
      if (exp_res.exists(e)) check("o_result", res, exp_res[e]);
   endtask

   task automatic step(input bit c, input bit s, input logic [IW-1:0] re,
                       input logic [IW-1:0] im, input bit b);
      @(negedge clk);
      rst = 1'b0; ce = c; sync = s; smp = {re, im}; byp = b;
      @(posedge clk);
      #1;
      if (c) begin
         model_edge(s, {re, im}, b);
         n_edge++;
         if (osync && first_osync < 0) first_osync = n_edge - 1;
         if (osync && cap_arm) begin
            cap_arm = 1'b0;
            cap_n   = 0;
         end
         if (cap_n < N) begin
            cap[cap_n] = res[31:16];
            cap_n++;
         end
      end
      if (n_edge > 0) check_out();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; ce = 1'($urandom); sync = 1'b0;
      @(posedge clk);
      #1;
      started = 1'b0;
      frame_q.delete();
      exp_sync.delete();
      exp_resync.delete();
      exp_res.delete();
      check("rst_result", res, 32'h0);
      check("rst_sync", 32'(osync), 32'h0);
      check("rst_resync", 32'(oresync), 32'h0);
   endtask

   // pat 0: bit-reversed ramp, 1: ramp, 2: random. len < N leaves a partial frame.
   task automatic send_frame(input int pat, input bit b1, input bit b2, input bit rce,
                             input int len);
      int i = 0;
      while (i < len) begin
         bit          c;
         logic [IW-1:0] re, im;
         c = rce ? ($urandom_range(0, 3) != 0) : 1'b1;
         case (pat)
            0:       re = IW'(bitrev(i) * 64);
            1:       re = IW'(i * 64);
            default: re = IW'($urandom);
         endcase
         im = (pat == 2) ? IW'($urandom) : -re;
         step(c, (i == 0), re, im, (i < N / 2) ? b1 : b2);
         if (c) i++;
      end
   endtask

   logic [IW-1:0] t5_in[N];

   initial begin
      rst = 1'b1; ce = 1'b0; sync = 1'b0; smp = '0; byp = 1'b0;
      do_reset();
      do_reset();

      // Samples before the first sync are discarded.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, IW'(1000 + i * 64), IW'(7), 1'b0);
      for (int f = 0; f < 4; f++) send_frame(0, 1'b0, 1'b0, 1'b0, N);
      check("sync_lat", 32'(first_osync - first_sync), 32'd10);

      // Bypass, and a mid-frame bypass change.
      send_frame(1, 1'b1, 1'b1, 1'b0, N);
      send_frame(1, 1'b1, 1'b1, 1'b0, N);
      send_frame(1, 1'b1, 1'b0, 1'b0, N);
      send_frame(1, 1'b0, 1'b0, 1'b0, N);
      send_frame(0, 1'b0, 1'b0, 1'b0, N);

      // Early sync at index 5.
      send_frame(2, 1'b0, 1'b0, 1'b0, N);
      send_frame(2, 1'b0, 1'b0, 1'b0, 5);
      send_frame(2, 1'b0, 1'b0, 1'b0, N);
      send_frame(2, 1'b0, 1'b0, 1'b0, N);

      // Rounding and saturation, replayed in received order.
      t5_in = '{22'h000020, 22'h000060, 22'h0000A0, 22'h0000E0,
                22'h1FFFFF, 22'h3FFFE0, 22'h000000, 22'h000000};
      for (int i = 0; i < N; i++) step(1'b1, (i == 0), t5_in[i], IW'($urandom), 1'b1);
      cap_arm = 1'b1;
      send_frame(2, 1'b0, 1'b0, 1'b0, N);
      check("t5_0x20", 32'(cap[0]), 32'h0000);
      check("t5_0x60", 32'(cap[1]), 32'h0002);
      check("t5_0xA0", 32'(cap[2]), 32'h0002);
      check("t5_0xE0", 32'(cap[3]), 32'h0004);
      check("t5_sat", 32'(cap[4]), 32'h7FFF);
      check("t5_neg", 32'(cap[5]), 32'h0000);

      // Random clock enable, random data and bypass, occasional early sync.
      for (int f = 0; f < 8; f++) begin
         bit b;
         b = 1'($urandom);
         send_frame(2, b, b, 1'b1, (f == 3) ? 4 : N);
      end
      send_frame(0, 1'b0, 1'b0, 1'b1, N);
      send_frame(0, 1'b0, 1'b0, 1'b1, N);

      // Reset mid-frame at index 3, then restart after unsynced samples.
      send_frame(2, 1'b0, 1'b0, 1'b0, 3);
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, IW'($urandom), IW'($urandom), 1'b0);
      send_frame(0, 1'b0, 1'b0, 1'b1, N);
      send_frame(2, 1'b1, 1'b1, 1'b1, N);
      send_frame(2, 1'b0, 1'b0, 1'b0, N);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
